bus_reader: RTL



---
 rtl/bus_reader_pkg.sv | 15 +
 rtl/bus_reader_fifo.sv | 68 ++++++
 rtl/bus_reader.sv | 89 ++++++++
 3 files changed

// File: rtl/bus_reader_pkg.sv
// Shared constants and helpers for the bus_reader receive path.
package bus_reader_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int unsigned MaxWidth = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(logic [MaxWidth-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bus_reader_fifo.sv
// Word buffer for bus_reader: memory, wrapping pointers and occupancy count.
module bus_reader_fifo
    import bus_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/bus_reader.sv
// Receiving end of the shared tristate bus: captures strobed words into a FIFO
// and offers them downstream over valid/ready. Optional parity check: BUS_READER_PARITY_EN.
module bus_reader
    import bus_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef BUS_READER_PARITY_EN
    input  logic                     bus_parity,
    output logic                     parity_err,
`endif
    input  logic [WIDTH-1:0]         bus_data,
    input  logic                     bus_load,
    output logic                     bus_busy,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic word_ok;
    logic overflow_q, overflow_d;

`ifdef BUS_READER_PARITY_EN
    logic                parity_err_q, parity_err_d;
    logic [MaxWidth-1:0] word_ext;

    always_comb begin
        word_ext              = '0;
        word_ext[WIDTH-1:0]   = bus_data;
        word_ok               = (even_parity(word_ext) == bus_parity);
        parity_err_d          = parity_err_q | (bus_load & ~word_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign word_ok = 1'b1;
`endif

    // Fullness is judged before any same-cycle pop, so a load into a full
    // FIFO is always dropped even while the consumer drains a word.
    assign push       = bus_load & ~full & word_ok;
    assign pop        = out_valid & out_ready;
    assign overflow_d = overflow_q | (bus_load & full);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign bus_busy  = full;
    assign out_valid = ~empty;

    bus_reader_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus_data),
        .pop     (pop),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule
